// File: rtl/branch_seq.sv
// branch_seq -- multicycle conditional-branch sequencer.
//
// The main control FSM pulses start. The sequencer then runs the shared ALU
// through a compare and registers the Igual/Maior/Menor flags. It evaluates
// the branch condition from those flags. A taken branch also gets a
// target-address add and a one-cycle PC write.
//
// Optional feature: define BRANCH_STATS_EN to build the taken/not-taken
// statistics counters. When it is undefined, the counter outputs are tied to
// 0 and stat_clr is ignored. The ports are the same in both builds.
//
// Ports
//   clk                    rising-edge clock
//   reset                  asynchronous, active-low reset
//   start                  one-cycle branch request (sampled in IDLE only)
//   Opcode[5:0]            opcode, latched when start is accepted
//   Igual/Maior/Menor      ALU flags, valid while the compare is driven
//   alu_src_a              ALU A select (0 = PC, 1 = rs)
//   alu_src_b[1:0]         ALU B select (00 rt, 01 +4, 10 zero, 11 offset<<2)
//   alu_op[2:0]            ALU op (000 idle, 001 add, 010 sub)
//   pc_write               PC load enable
//   busy                   high outside IDLE
//   done                   one-cycle completion pulse
//   taken / illegal        decision, valid while done is high
//   stat_clr               synchronous clear of the statistics counters
//   stat_taken/_not_taken  saturating statistics counters (STAT_W bits)
module branch_seq #(
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        Opcode,
  input  logic              Igual,
  input  logic              Maior,
  input  logic              Menor,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [2:0]        alu_op,
  output logic              pc_write,
  output logic              busy,
  output logic              done,
  output logic              taken,
  output logic              illegal,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_not_taken
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMP    = 3'd1,
    S_EVAL   = 3'd2,
    S_TARGET = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e     state_q;
  logic [5:0] opcode_q;
  logic       igual_q, maior_q, menor_q;
  logic       done_q, taken_q, illegal_q;

  // Branch condition from the registered flags. Each opcode reads only its
  // own flag. Unknown opcodes are never taken and are flagged illegal.
  logic cond, ill;
  always_comb begin
    cond = 1'b0;
    ill  = 1'b0;
    case (opcode_q)
      6'd4:    cond = igual_q;
      6'd5:    cond = ~igual_q;
      6'd6:    cond = ~maior_q;
      6'd7:    cond = maior_q;
      6'd1:    cond = menor_q;
      default: ill  = 1'b1;
    endcase
  end

  // Sequencer FSM. done/taken/illegal are loaded on the edge that enters
  // DONE and cleared on the way out, so they read 0 outside DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      igual_q   <= 1'b0;
      maior_q   <= 1'b0;
      menor_q   <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            opcode_q <= Opcode;
            state_q  <= S_CMP;
          end
        end
        S_CMP: begin
          igual_q <= Igual;
          maior_q <= Maior;
          menor_q <= Menor;
          state_q <= S_EVAL;
        end
        S_EVAL: begin
          if (cond) begin
            state_q <= S_TARGET;
          end else begin
            state_q   <= S_DONE;
            done_q    <= 1'b1;
            taken_q   <= 1'b0;
            illegal_q <= ill;
          end
        end
        S_TARGET: begin
          state_q   <= S_DONE;
          done_q    <= 1'b1;
          taken_q   <= 1'b1;
          illegal_q <= 1'b0;
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          done_q    <= 1'b0;
          taken_q   <= 1'b0;
          illegal_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ALU control and PC write decode straight from the state register.
  always_comb begin
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op    = 3'b000;
    pc_write  = 1'b0;
    case (state_q)
      S_CMP: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
        // beq/bne compare rs against rt; the others compare rs against zero.
        alu_src_b = (opcode_q == 6'd4 || opcode_q == 6'd5) ? 2'b00 : 2'b10;
      end
      S_TARGET: begin
        alu_src_a = 1'b0;
        alu_src_b = 2'b11;
        alu_op    = 3'b001;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign taken   = taken_q;
  assign illegal = illegal_q;

`ifdef BRANCH_STATS_EN
  logic [STAT_W-1:0] st_q, snt_q;
  logic              enter_done, enter_taken;

  assign enter_done  = (state_q == S_TARGET) || (state_q == S_EVAL && !cond);
  assign enter_taken = (state_q == S_TARGET);

  // Saturating counters. A clear that lands on an increment wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q  <= '0;
      snt_q <= '0;
    end else if (stat_clr) begin
      st_q  <= '0;
      snt_q <= '0;
    end else if (enter_done) begin
      if (enter_taken) begin
        if (st_q != '1) st_q <= st_q + STAT_W'(1);
      end else begin
        if (snt_q != '1) snt_q <= snt_q + STAT_W'(1);
      end
    end
  end

  assign stat_taken     = st_q;
  assign stat_not_taken = snt_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_taken      = '0;
  assign stat_not_taken  = '0;
`endif

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq. A transaction-level model builds the
// expected per-cycle output trace for each accepted branch. The model fixes
// the decision when the compare cycle ends. It is compared against the DUT
// on every falling edge. The directed tasks also carry literal expectations
// (done cycle, decision, CMP-cycle ALU selects, counter values).
module tb_branch_seq;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  Opcode = '0;
  logic        Igual = 1'b0, Maior = 1'b0, Menor = 1'b0;
  logic        stat_clr = 1'b0;
  logic        alu_src_a, pc_write, busy, done, taken, illegal;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [15:0] stat_taken, stat_not_taken;
  logic        unused_s_a, unused_s_pcw, unused_s_busy, unused_s_done, unused_s_tk, unused_s_ill;
  logic [1:0]  unused_s_b;
  logic [2:0]  unused_s_op;
  logic [1:0]  s_st, s_snt;

  always #5 clk = ~clk;

  branch_seq #(.STAT_W(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .Opcode(Opcode),
    .Igual(Igual), .Maior(Maior), .Menor(Menor),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_write(pc_write), .busy(busy), .done(done), .taken(taken),
    .illegal(illegal), .stat_clr(stat_clr),
    .stat_taken(stat_taken), .stat_not_taken(stat_not_taken)
  );

  // Narrow-counter copy, used for the saturation check.
  branch_seq #(.STAT_W(2)) u_sat (
    .clk(clk), .reset(reset), .start(start), .Opcode(Opcode),
    .Igual(Igual), .Maior(Maior), .Menor(Menor),
    .alu_src_a(unused_s_a), .alu_src_b(unused_s_b), .alu_op(unused_s_op),
    .pc_write(unused_s_pcw), .busy(unused_s_busy), .done(unused_s_done),
    .taken(unused_s_tk), .illegal(unused_s_ill), .stat_clr(stat_clr),
    .stat_taken(s_st), .stat_not_taken(s_snt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    bit       busy, done, taken, illegal, pc_write, a;
    bit [1:0] b;
    bit [2:0] op;
    bit       cmp;
    bit [5:0] opc;
  } rec_t;

  localparam rec_t R_IDLE = '0;

  rec_t cur = R_IDLE;
  rec_t nxt;
  rec_t q[$];
  int   m_st = 0, m_snt = 0, m_sst = 0, m_ssnt = 0;

  function automatic bit is_legal(input bit [5:0] op);
    return op == 6'd4 || op == 6'd5 || op == 6'd6 || op == 6'd7 || op == 6'd1;
  endfunction

  function automatic bit decide(input bit [5:0] op, input bit ig, ma, me);
    case (op)
      6'd4: return ig;
      6'd5: return !ig;
      6'd6: return !ma;
      6'd7: return ma;
      6'd1: return me;
      default: return 1'b0;
    endcase
  endfunction

  function automatic rec_t mk(input bit busy_, done_, tk, ill, pcw, a_,
                              input bit [1:0] b_, input bit [2:0] op_,
                              input bit cmp_, input bit [5:0] opc_);
    rec_t r;
    r.busy = busy_; r.done = done_; r.taken = tk; r.illegal = ill;
    r.pc_write = pcw; r.a = a_; r.b = b_; r.op = op_; r.cmp = cmp_; r.opc = opc_;
    return r;
  endfunction

  always begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      q.delete();
      cur = R_IDLE;
      m_st = 0; m_snt = 0; m_sst = 0; m_ssnt = 0;
    end else begin
      if (q.size() > 0) nxt = q.pop_front();
      else if (cur.cmp) begin
        bit tk;
        tk  = decide(cur.opc, Igual, Maior, Menor);
        nxt = mk(1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0, cur.opc);   // EVAL
        if (tk) begin
          q.push_back(mk(1, 0, 0, 0, 1, 0, 2'b11, 3'b001, 0, cur.opc));
          q.push_back(mk(1, 1, 1, 0, 0, 0, 2'b00, 3'b000, 0, cur.opc));
        end else
          q.push_back(mk(1, 1, 0, !is_legal(cur.opc), 0, 0, 2'b00, 3'b000, 0, cur.opc));
      end else if (!cur.busy && start)
        nxt = mk(1, 0, 0, 0, 0, 1, (Opcode == 6'd4 || Opcode == 6'd5) ? 2'b00 : 2'b10,
                 3'b010, 1, Opcode);
      else nxt = R_IDLE;
      if (STATS) begin
        if (stat_clr) begin
          m_st = 0; m_snt = 0; m_sst = 0; m_ssnt = 0;
        end else if (nxt.done) begin
          if (nxt.taken) begin
            if (m_st < 65535) m_st++;
            if (m_sst < 3) m_sst++;
          end else begin
            if (m_snt < 65535) m_snt++;
            if (m_ssnt < 3) m_ssnt++;
          end
        end
      end
      cur = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(negedge clk);
    chk("busy", 32'(busy), 32'(cur.busy));
    chk("done", 32'(done), 32'(cur.done));
    chk("taken", 32'(taken), 32'(cur.taken));
    chk("illegal", 32'(illegal), 32'(cur.illegal));
    chk("pc_write", 32'(pc_write), 32'(cur.pc_write));
    chk("alu_src_a", 32'(alu_src_a), 32'(cur.a));
    chk("alu_src_b", 32'(alu_src_b), 32'(cur.b));
    chk("alu_op", 32'(alu_op), 32'(cur.op));
    chk("stat_taken", 32'(stat_taken), 32'(m_st));
    chk("stat_not_taken", 32'(stat_not_taken), 32'(m_snt));
    chk("sat_taken", 32'(s_st), 32'(m_sst));
    chk("sat_not_taken", 32'(s_snt), 32'(m_ssnt));
  end

  // ---------------- directed stimulus ----------------
  // Called on a falling edge. Start is raised for edge E0, then the task
  // watches cycles 1..6. xs/clr_c raise start/stat_clr during that cycle.
  task automatic run_branch(input bit [5:0] op, input bit ig, ma, me,
                            input bit exp_tk, exp_ill, input int xs, input int clr_c);
    int       ndone = 0, dcyc = 0;
    bit       tk_at = 0, ill_at = 0, pcw = 0;
    bit [1:0] b1 = 0;
    bit [2:0] op1 = 0;
    Opcode = op; Igual = ig; Maior = ma; Menor = me; start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start    = (k == xs);
      stat_clr = (k == clr_c);
      if (k == 1) begin b1 = alu_src_b; op1 = alu_op; end
      if (done) begin ndone++; dcyc = k; tk_at = taken; ill_at = illegal; end
      if (pc_write) pcw = 1'b1;
    end
    start = 1'b0; stat_clr = 1'b0;
    chk("lit_done_count", 32'(ndone), 32'd1);
    chk("lit_done_cycle", 32'(dcyc), exp_tk ? 32'd4 : 32'd3);
    chk("lit_taken", 32'(tk_at), 32'(exp_tk));
    chk("lit_illegal", 32'(ill_at), 32'(exp_ill));
    chk("lit_pc_write_seen", 32'(pcw), 32'(exp_tk));
    chk("lit_cmp_src_b", 32'(b1), (op == 6'd4 || op == 6'd5) ? 32'd0 : 32'd2);
    chk("lit_cmp_alu_op", 32'(op1), 32'd2);
  endtask

  task automatic clr_pulse;
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    @(negedge clk);
    chk("lit_clr_taken", 32'(stat_taken), 32'd0);
    chk("lit_clr_not_taken", 32'(stat_not_taken), 32'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    chk("lit_rst_stats", 32'(stat_taken), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // beq / bne
    run_branch(6'd4, 1, 0, 0, 1, 0, 0, 0);
    run_branch(6'd4, 0, 1, 0, 0, 0, 0, 0);
    run_branch(6'd5, 1, 0, 0, 0, 0, 0, 0);
    run_branch(6'd5, 0, 0, 1, 1, 0, 0, 0);
    // blez / bgtz / bltz sweep
    run_branch(6'd6, 0, 0, 1, 1, 0, 0, 0);
    run_branch(6'd6, 1, 0, 0, 1, 0, 0, 0);
    run_branch(6'd6, 0, 1, 0, 0, 0, 0, 0);
    run_branch(6'd7, 0, 1, 0, 1, 0, 0, 0);
    run_branch(6'd7, 0, 0, 1, 0, 0, 0, 0);
    run_branch(6'd1, 0, 0, 1, 1, 0, 0, 0);
    run_branch(6'd1, 0, 1, 0, 0, 0, 0, 0);
    run_branch(6'd1, 1, 0, 0, 0, 0, 0, 0);
    // Illegal opcodes; the first one has a second start during CMP.
    run_branch(6'd2, 1, 1, 1, 0, 1, 1, 0);
    run_branch(6'd0, 1, 0, 0, 0, 1, 0, 0);

    // Reset while in TARGET.
    Opcode = 6'd4; Igual = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("lit_target_pc_write", 32'(pc_write), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("lit_rst_pc_write", 32'(pc_write), 32'd0);
    chk("lit_rst_outputs", 32'({alu_src_a, alu_src_b, alu_op, busy, done, taken, illegal}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_branch(6'd4, 1, 0, 0, 1, 0, 0, 0);

    // Statistics: 3 taken, 2 not taken.
    clr_pulse();
    run_branch(6'd4, 1, 0, 0, 1, 0, 0, 0);
    run_branch(6'd7, 0, 1, 0, 1, 0, 0, 0);
    run_branch(6'd5, 1, 0, 0, 0, 0, 0, 0);
    run_branch(6'd1, 0, 0, 1, 1, 0, 0, 0);
    run_branch(6'd6, 0, 1, 0, 0, 0, 0, 0);
    chk("lit_stat_taken_3", 32'(stat_taken), STATS ? 32'd3 : 32'd0);
    chk("lit_stat_not_taken_2", 32'(stat_not_taken), STATS ? 32'd2 : 32'd0);
    // Clear lands on the edge that enters DONE of a not-taken branch.
    run_branch(6'd5, 1, 0, 0, 0, 0, 0, 2);
    chk("lit_clr_wins_taken", 32'(stat_taken), 32'd0);
    chk("lit_clr_wins_not_taken", 32'(stat_not_taken), 32'd0);
    // Saturation on the 2-bit copy.
    for (int i = 0; i < 5; i++) run_branch(6'd4, 1, 0, 0, 1, 0, 0, 0);
    chk("lit_sat_taken", 32'(s_st), STATS ? 32'd3 : 32'd0);
    chk("lit_wide_taken_5", 32'(stat_taken), STATS ? 32'd5 : 32'd0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
